// File: rtl/phys_free_list_if.sv
// ---------------------------------------------------------------------------
// phys_free_list_if
//
// Groups the signals between the physical free list and its users: the
// rename stage (allocation), the two retire slots (release) and the
// status/error outputs.
//
// Handshake: a tag is popped at the posedge where alloc_req and alloc_valid
// are both high; alloc_tag is show-ahead and stays stable until that edge.
// A release slot hands over rel*_tag at the posedge where rel*_valid is
// high; there is no ready, the free list accepts or silently drops it.
//
// Modports:
//   master - rename/retire side: drives alloc_req and the release slots,
//            observes alloc_valid, alloc_tag, free_count, full, list_error.
//   slave  - the free list itself.
// ---------------------------------------------------------------------------
interface phys_free_list_if #(
    parameter int PREG_WIDTH = 6,
    parameter int PTR_WIDTH  = 5
);
    logic                  alloc_req;
    logic                  alloc_valid;
    logic [PREG_WIDTH-1:0] alloc_tag;
    logic                  rel0_valid;
    logic [PREG_WIDTH-1:0] rel0_tag;
    logic                  rel1_valid;
    logic [PREG_WIDTH-1:0] rel1_tag;
    logic [PTR_WIDTH:0]    free_count;
    logic                  full;
    logic                  list_error;

    modport master (
        output alloc_req, rel0_valid, rel0_tag, rel1_valid, rel1_tag,
        input  alloc_valid, alloc_tag, free_count, full, list_error
    );

    modport slave (
        input  alloc_req, rel0_valid, rel0_tag, rel1_valid, rel1_tag,
        output alloc_valid, alloc_tag, free_count, full, list_error
    );
endinterface

// File: rtl/phys_free_list.sv
// ---------------------------------------------------------------------------
// phys_free_list
//
// Circular FIFO of unallocated physical register tags. The rename stage pops
// fresh destination tags from the head; up to two retiring instructions per
// cycle push their previous mappings back at the tail.
//
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous, active-high reset
//   fl   - phys_free_list_if.slave: alloc_req/alloc_valid/alloc_tag,
//          rel0_valid/rel0_tag, rel1_valid/rel1_tag, free_count, full,
//          list_error
//
// Optional feature, macro FREE_LIST_CHECK_EN:
//   defined   - an "is free" bitmap catches double frees (dropped, flagged
//               in list_error and reported); overflow also flags list_error.
//   undefined - no bitmap, list_error tied to 0; overflow still dropped.
//
// DEPTH must be a power of two so head/tail wrap by plain overflow.
// ---------------------------------------------------------------------------
module phys_free_list #(
    parameter int PREG_WIDTH = 6,
    parameter int NUM_PREG   = 64,
    parameter int NUM_AREG   = 32,
    parameter int DEPTH      = NUM_PREG - NUM_AREG,
    parameter int PTR_WIDTH  = 5
) (
    input  logic          clk,
    input  logic          rst,
    phys_free_list_if.slave fl
);
    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);

    logic [PREG_WIDTH-1:0] entry_q [DEPTH];
    logic [PTR_WIDTH-1:0]  head_q, head_d;
    logic [PTR_WIDTH-1:0]  tail_q, tail_d;
    logic [PTR_WIDTH-1:0]  slot1_ptr;
    logic [PTR_WIDTH:0]    count_q, count_d;
    logic [PTR_WIDTH:0]    room;
    logic                  pop;
    logic                  base0, base1;
    logic                  cand0, cand1;
    logic                  keep0, keep1;

    // Outputs come straight from registered state: no release-to-alloc bypass.
    assign fl.alloc_valid = (count_q != '0);
    assign fl.alloc_tag   = entry_q[head_q];
    assign fl.free_count  = count_q;
    assign fl.full        = (count_q == DEPTH_C);

    // A release needs its valid bit and a nonzero tag; x0 is never freed.
    assign base0 = fl.rel0_valid && (fl.rel0_tag != '0);
    assign base1 = fl.rel1_valid && (fl.rel1_tag != '0);

`ifdef FREE_LIST_CHECK_EN
    logic [NUM_PREG-1:0] free_q;
    logic                error_q;
    logic                dbl0, dbl1;
    logic                overflow;

    // Slot 1 is also a double free when it repeats slot 0's tag this cycle.
    assign dbl0  = base0 && free_q[fl.rel0_tag];
    assign dbl1  = base1 && (free_q[fl.rel1_tag] ||
                             (base0 && (fl.rel1_tag == fl.rel0_tag)));
    assign cand0 = base0 && !dbl0;
    assign cand1 = base1 && !dbl1;
    assign overflow = (cand0 && !keep0) || (cand1 && !keep1);
    assign fl.list_error = error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREG; i++) begin
                free_q[i] <= (i >= NUM_AREG);
            end
            error_q <= 1'b0;
        end else begin
            if (pop)   free_q[fl.alloc_tag] <= 1'b0;
            if (keep0) free_q[fl.rel0_tag]  <= 1'b1;
            if (keep1) free_q[fl.rel1_tag]  <= 1'b1;
            if (overflow || dbl0 || dbl1) error_q <= 1'b1;
            if (dbl0) $display("phys_free_list: double free of tag %0d (slot 0)", fl.rel0_tag);
            if (dbl1) $display("phys_free_list: double free of tag %0d (slot 1)", fl.rel1_tag);
        end
    end
`else
    assign cand0 = base0;
    assign cand1 = base1;
    assign fl.list_error = 1'b0;
`endif

    always_comb begin
        pop  = fl.alloc_req && (count_q != '0);
        // Occupancy after the pop; a pop frees one slot for a same-cycle release.
        room = count_q - (PTR_WIDTH+1)'(pop);
        // Slot 0 gets first claim on the remaining space.
        keep0 = cand0 && (room < DEPTH_C);
        keep1 = cand1 && ((room + (PTR_WIDTH+1)'(keep0)) < DEPTH_C);
        slot1_ptr = tail_q + PTR_WIDTH'(keep0);
        head_d  = head_q + PTR_WIDTH'(pop);
        tail_d  = tail_q + PTR_WIDTH'(keep0) + PTR_WIDTH'(keep1);
        count_d = room + (PTR_WIDTH+1)'(keep0) + (PTR_WIDTH+1)'(keep1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= PREG_WIDTH'(NUM_AREG + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= DEPTH_C;
        end else begin
            // When full with a concurrent pop, tail == head: the write lands
            // in the entry being popped, which was already read this cycle.
            if (keep0) entry_q[tail_q]    <= fl.rel0_tag;
            if (keep1) entry_q[slot1_ptr] <= fl.rel1_tag;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;
  localparam int PW = 6;
  localparam int QW = 5;
`ifdef FREE_LIST_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phys_free_list_if #(.PREG_WIDTH(PW), .PTR_WIDTH(QW)) fl ();

  phys_free_list #(
    .PREG_WIDTH(PW), .NUM_PREG(64), .NUM_AREG(32), .DEPTH(32), .PTR_WIDTH(QW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fl (fl)
  );

  // scoreboard: tags expected to come out of the list, in order
  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic req, input logic v0, input logic [PW-1:0] t0,
                       input logic v1, input logic [PW-1:0] t1);
    fl.alloc_req  = req;
    fl.rel0_valid = v0;
    fl.rel0_tag   = t0;
    fl.rel1_valid = v1;
    fl.rel1_tag   = t1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic reset_model;
    exp_q.delete();
    for (int i = 32; i < 64; i++) exp_q.push_back(PW'(i));
  endtask

  // Checks the head against the scoreboard and requests a pop this cycle.
  task automatic expect_pop(input string tag);
    logic [PW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed pop request, expected scoreboard entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(fl.alloc_valid), 32'd1);
      chk(tag, 32'(fl.alloc_tag), 32'(e));
    end
    fl.alloc_req = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();

    // reset state
    chk("rst_valid", 32'(fl.alloc_valid), 32'd1);
    chk("rst_tag", 32'(fl.alloc_tag), 32'd32);
    chk("rst_count", 32'(fl.free_count), 32'd32);
    chk("rst_full", 32'(fl.full), 32'd1);
    chk("rst_err", 32'(fl.list_error), 32'd0);

    // drain the whole list: 32..63
    for (int i = 0; i < 32; i++) begin
      expect_pop($sformatf("drain_%0d", i));
      tick();
    end
    chk("empty_valid", 32'(fl.alloc_valid), 32'd0);
    chk("empty_count", 32'(fl.free_count), 32'd0);
    chk("empty_full", 32'(fl.full), 32'd0);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    chk("empty_pop_count", 32'(fl.free_count), 32'd0);
    chk("empty_pop_valid", 32'(fl.alloc_valid), 32'd0);

    // double release into an empty list; no same-cycle bypass
    drive(1'b0, 1'b1, 6'd40, 1'b1, 6'd45);
    #1;
    chk("no_bypass_valid", 32'(fl.alloc_valid), 32'd0);
    tick();
    exp_q.push_back(6'd40);
    exp_q.push_back(6'd45);
    chk("dbl_rel_count", 32'(fl.free_count), 32'd2);
    expect_pop("dbl_rel_first");
    tick();
    expect_pop("dbl_rel_second");
    tick();

    // build free_count = 5, including a slot-1-only release
    drive(1'b0, 1'b1, 6'd34, 1'b1, 6'd35); tick();
    drive(1'b0, 1'b1, 6'd36, 1'b1, 6'd37); tick();
    drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd38);  tick();
    for (int i = 34; i <= 38; i++) exp_q.push_back(PW'(i));
    chk("five_count", 32'(fl.free_count), 32'd5);
    // pop with concurrent release keeps the count; 50 lands at the tail
    drive(1'b0, 1'b1, 6'd50, 1'b0, '0);
    expect_pop("pop_rel_head");
    tick();
    exp_q.push_back(6'd50);
    chk("pop_rel_count", 32'(fl.free_count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      expect_pop($sformatf("pop_rel_drain_%0d", i));
      tick();
    end

    // tag 0 on slot 0 is dropped
    drive(1'b0, 1'b1, 6'd0, 1'b1, 6'd33);
    tick();
    exp_q.push_back(6'd33);
    chk("x0_count", 32'(fl.free_count), 32'd1);
    expect_pop("x0_only33");
    tick();

    // walk head/tail from 9 to 31 with one tag in flight
    drive(1'b0, 1'b1, 6'd1, 1'b0, '0);
    tick();
    exp_q.push_back(6'd1);
    for (int i = 2; i <= 22; i++) begin
      drive(1'b0, 1'b1, PW'(i), 1'b0, '0);
      expect_pop($sformatf("walk_%0d", i));
      tick();
      exp_q.push_back(PW'(i));
    end
    expect_pop("walk_last");
    tick();
    chk("walk_empty_count", 32'(fl.free_count), 32'd0);

    // double release at tail = 31 wraps slot 1 to entry 0
    drive(1'b0, 1'b1, 6'd60, 1'b1, 6'd61);
    tick();
    exp_q.push_back(6'd60);
    exp_q.push_back(6'd61);
    chk("wrap_count", 32'(fl.free_count), 32'd2);
    expect_pop("wrap_first");
    tick();
    expect_pop("wrap_second");
    tick();
    chk("pre_ovf_err", 32'(fl.list_error), 32'd0);

    // fill to full with tags 10..41
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, PW'(10 + 2 * k), 1'b1, PW'(11 + 2 * k));
      tick();
      exp_q.push_back(PW'(10 + 2 * k));
      exp_q.push_back(PW'(11 + 2 * k));
    end
    chk("fill_full", 32'(fl.full), 32'd1);
    chk("fill_count", 32'(fl.free_count), 32'd32);

    // overflow: both releases dropped while full
    drive(1'b0, 1'b1, 6'd62, 1'b1, 6'd63);
    tick();
    chk("ovf_count", 32'(fl.free_count), 32'd32);
    chk("ovf_err", 32'(fl.list_error), 32'(CHK));
    // full + pop + two releases: slot 0 kept, slot 1 dropped
    drive(1'b0, 1'b1, 6'd62, 1'b1, 6'd63);
    expect_pop("full_pop_rel");
    tick();
    exp_q.push_back(6'd62);
    chk("full_pop_rel_count", 32'(fl.free_count), 32'd32);
    for (int i = 0; i < 32; i++) begin
      expect_pop($sformatf("full_drain_%0d", i));
      tick();
    end
    chk("full_drain_count", 32'(fl.free_count), 32'd0);

    // reset mid-sequence dominates concurrent alloc/release
    drive(1'b0, 1'b1, 6'd5, 1'b0, '0);
    tick();
    drive(1'b1, 1'b1, 6'd7, 1'b1, 6'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_model();
    chk("midrst_tag", 32'(fl.alloc_tag), 32'd32);
    chk("midrst_count", 32'(fl.free_count), 32'd32);
    chk("midrst_err", 32'(fl.list_error), 32'd0);
    expect_pop("midrst_pop");
    tick();

    // release 40, still marked free since reset
    drive(1'b0, 1'b1, 6'd40, 1'b0, '0);
    tick();
    if (!CHK) exp_q.push_back(6'd40);
    chk("dblfree_count", 32'(fl.free_count), CHK ? 32'd31 : 32'd32);
    chk("dblfree_err", 32'(fl.list_error), 32'(CHK));
    expect_pop("after_dblfree_pop");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/phys_free_list.md
# phys_free_list

Circular FIFO of unallocated physical register tags, sitting directly upstream of the architectural register file / rename table. It supplies the fresh `rd_tag` used when an instruction's destination is renamed. It reclaims the previous mapping (`rd_old_tag`) of up to two retiring instructions per cycle, matching the two retire ports.

## Interface
- `PREG_WIDTH`, 6: physical tag width.
- `NUM_PREG`, 64: total physical registers.
- `NUM_AREG`, 32: architectural registers; tags 0..NUM_AREG-1 are mapped at reset.
- `DEPTH`, NUM_PREG-NUM_AREG (32): FIFO capacity; must be a power of two.
- `PTR_WIDTH`, 5: log2(DEPTH).

Ports:
- `clk` input 1: single clock, all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `alloc_req` input 1: rename stage consumes a tag this cycle.
- `alloc_valid` output 1: a free tag is available (`free_count != 0`).
- `alloc_tag` output PREG_WIDTH: tag at head (show-ahead).
- `rel0_valid` input 1: retire slot 0 returns a tag.
- `rel0_tag` input PREG_WIDTH: tag returned by slot 0.
- `rel1_valid` input 1: retire slot 1 returns a tag.
- `rel1_tag` input PREG_WIDTH: tag returned by slot 1.
- `free_count` output PTR_WIDTH+1: number of free tags held.
- `full` output 1: `free_count == DEPTH`.
- `list_error` output 1: sticky error flag (see Configuration).

## Operation
- Storage: DEPTH entries of PREG_WIDTH bits, plus `head` and `tail` pointers (PTR_WIDTH each, wrap modulo DEPTH) and `free_count`.
- Reset:
  - entry[i] = NUM_AREG+i; head = 0; tail = 0; free_count = DEPTH.
  - Outputs after reset: alloc_valid = 1, alloc_tag = 32, free_count = 32, full = 1, list_error = 0.
- Allocate:
  - Pop occurs only when `alloc_req && alloc_valid`; head increments by 1.
  - `alloc_req` while empty is ignored; no state change.
- Release:
  - A release is accepted only when its valid bit is set and its tag is nonzero. Tag 0 (x0) is never freed and is silently dropped.
  - Accepted tags are written in slot order: slot 0 goes to `tail`, slot 1 goes to `tail+1`. If only one slot is accepted, it goes to `tail`.
  - tail advances by the accepted count (0, 1 or 2).
- Count update: `free_count_next = free_count + accepted_releases - pop`, computed in PTR_WIDTH+1 bits.
- Overflow: a release that would push `free_count` past DEPTH is dropped. Slot 0 has priority over slot 1. An overflow sets `list_error`.
- Simultaneous pop and release are legal in the same cycle, including when the list is full or empty.

## Timing
- `alloc_tag`, `alloc_valid`, `free_count` and `full` are combinational from registered state. There is zero-cycle latency from state to output.
- A popped tag is removed at the posedge. The next tag appears right after that edge.
- A released tag becomes allocatable the cycle after its release edge. There is no same-cycle release-to-alloc bypass: an empty list with a concurrent release still shows `alloc_valid = 0` that cycle.
- Reset dominates: `rst` high at a posedge discards any concurrent alloc or release and restores the reset state. This includes reset mid-sequence.
- Pointer wrap: the index after DEPTH-1 is 0, for both head and tail. For a double release at tail = DEPTH-1, the slot 1 tag is written to entry 0.

## Configuration
- `FREE_LIST_CHECK_EN` defined:
  - Compiles in a NUM_PREG-bit "is free" bitmap. Reset value: bits NUM_AREG..NUM_PREG-1 set.
  - Releasing a tag whose bit is already set, or releasing the same tag on both slots in one cycle, is a double free. It sets `list_error`, drops the offending release, and issues `$display` with the tag.
  - Overflow also sets `list_error`. Allocation clears the bit of the popped tag.
- `FREE_LIST_CHECK_EN` undefined:
  - No bitmap and no double-free detection.
  - `list_error` is tied to 0.
  - Overflow releases are still dropped.

## Test plan
- Reset, then 32 consecutive cycles with `alloc_req=1` -> alloc_tag sequence is 32..63. After that, alloc_valid = 0 and free_count = 0; a further alloc_req leaves the state unchanged.
- List empty, rel0 = 40 and rel1 = 45 in the same cycle -> next cycle free_count = 2 and alloc_tag = 40; after one pop, alloc_tag = 45.
- free_count = 5, alloc_req together with rel0 = 50 -> free_count stays 5; tag 50 is placed at the tail.
- rel0 = 0 and rel1 = 33 with the list otherwise empty -> only 33 is enqueued; free_count = 1.
- Pointer wrap: with head = tail = 31 and the list empty, a double release of 60 and 61 -> 60 goes to entry 31 and 61 to entry 0; they pop in the order 60 then 61.
- With `FREE_LIST_CHECK_EN`: right after reset, release 40 -> list_error = 1 (double free); free_count stays 32. Asserting rst mid-sequence -> list_error = 0 and alloc_tag = 32.
